// File: rtl/tlul_host_bridge.sv
// rtl/tlul_host_bridge.sv - TL-UL host bridge: req/gnt command port to single-outstanding TL-UL initiator
//
// Contents: tlul_pkg (TL-UL channel types), tlul_cmd_intg_gen (A-channel
// integrity generator), tlul_host_bridge (top).
//
// tlul_host_bridge ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_i / gnt_o          command handshake, accepted when req_i & gnt_o
//   we_i, addr_i, wdata_i, be_i   command: write enable, byte address, data, byte enables
//   rvalid_o, rdata_o, err_o      one-cycle response pulse, read data (held), error
//   busy_o                 bridge not idle
//   tl_o / tl_i            TL-UL A channel + d_ready out, D channel + a_ready in
//
// Optional feature: define TLUL_HOST_BRIDGE_TIMEOUT_EN to enable the
// AReq/DWait timeout counter and the Drain state that swallows a late reply.

package tlul_pkg;
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [13:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

// Folds the command and data fields into 7-bit interleaved parity words.
module tlul_cmd_intg_gen (
    input  logic [2:0]  opcode,
    input  logic [31:0] address,
    input  logic [3:0]  mask,
    input  logic [31:0] data,
    output logic [6:0]  cmd_intg,
    output logic [6:0]  data_intg
);
    logic [38:0] cmd_vec;
    assign cmd_vec = {opcode, mask, address};

    always_comb begin
        cmd_intg  = '0;
        data_intg = '0;
        for (int i = 0; i < 39; i++) begin
            cmd_intg[i % 7] = cmd_intg[i % 7] ^ cmd_vec[i];
        end
        for (int i = 0; i < 32; i++) begin
            data_intg[i % 7] = data_intg[i % 7] ^ data[i];
        end
    end
endmodule

module tlul_host_bridge
    import tlul_pkg::*;
#(
    parameter logic [7:0] SrcId = 8'h00
`ifdef TLUL_HOST_BRIDGE_TIMEOUT_EN
    , parameter int unsigned TimeoutCycles = 1024
`endif
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o,
    output tl_h2d_t     tl_o,
    input  tl_d2h_t     tl_i
);
    typedef enum logic [2:0] {
        Idle,
        AReq,
        DWait,
        Resp
`ifdef TLUL_HOST_BRIDGE_TIMEOUT_EN
        , Drain
`endif
    } state_e;

    state_e      state_q, state_d;
    logic        we_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        load_resp;
    logic        accept;
    logic        misaligned;
    logic        rsp_err;
    logic [2:0]  a_opcode;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [31:0] a_address;
    logic [6:0]  cmd_intg, data_intg;

`ifdef TLUL_HOST_BRIDGE_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        drain_q;
    logic        set_drain;
    logic        timeout_hit;
    assign timeout_hit = (cnt_q == 16'(TimeoutCycles - 1));
`endif

    logic unused_tl;
    assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

    assign gnt_o      = (state_q == Idle);
    assign accept     = req_i & gnt_o;
    assign misaligned = (addr_i[1:0] != 2'b00);
    assign rvalid_o   = (state_q == Resp);
    assign busy_o     = (state_q != Idle);
    assign rdata_o    = rdata_q;
    assign err_o      = err_q;

    assign a_opcode  = we_q ? ((be_q == 4'hF) ? PutFullData : PutPartialData) : Get;
    assign a_mask    = we_q ? be_q : 4'hF;
    assign a_data    = we_q ? wdata_q : 32'h0;
    assign a_address = {addr_q, 2'b00};

    // The reply opcode must match the request class: reads expect data back.
    assign rsp_err = tl_i.d_error
                   | (we_q ? (tl_i.d_opcode != AccessAck) : (tl_i.d_opcode != AccessAckData))
                   | (tl_i.d_source != SrcId);

    tlul_cmd_intg_gen u_intg (
        .opcode    (a_opcode),
        .address   (a_address),
        .mask      (a_mask),
        .data      (a_data),
        .cmd_intg  (cmd_intg),
        .data_intg (data_intg)
    );

    always_comb begin
        tl_o                  = '0;
        tl_o.a_valid          = (state_q == AReq);
        tl_o.a_opcode         = a_opcode;
        tl_o.a_size           = 2'd2;
        tl_o.a_source         = SrcId;
        tl_o.a_address        = a_address;
        tl_o.a_mask           = a_mask;
        tl_o.a_data           = a_data;
        tl_o.a_user.cmd_intg  = cmd_intg;
        tl_o.a_user.data_intg = data_intg;
`ifdef TLUL_HOST_BRIDGE_TIMEOUT_EN
        tl_o.d_ready          = (state_q == DWait) || (state_q == Drain);
`else
        tl_o.d_ready          = (state_q == DWait);
`endif
    end

    always_comb begin
        state_d   = state_q;
        load_resp = 1'b0;
        err_d     = 1'b0;
        rdata_d   = 32'h0;
`ifdef TLUL_HOST_BRIDGE_TIMEOUT_EN
        set_drain = 1'b0;
`endif
        case (state_q)
            Idle: begin
                if (req_i) begin
                    if (misaligned) begin
                        // Misaligned commands never reach the bus.
                        state_d   = Resp;
                        load_resp = 1'b1;
                        err_d     = 1'b1;
                    end else begin
                        state_d = AReq;
                    end
                end
            end
            AReq: begin
                if (tl_i.a_ready) begin
                    state_d = DWait;
`ifdef TLUL_HOST_BRIDGE_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d   = Resp;
                    load_resp = 1'b1;
                    err_d     = 1'b1;
`endif
                end
            end
            DWait: begin
                if (tl_i.d_valid) begin
                    state_d   = Resp;
                    load_resp = 1'b1;
                    err_d     = rsp_err;
                    rdata_d   = (!we_q && !rsp_err) ? tl_i.d_data : 32'h0;
`ifdef TLUL_HOST_BRIDGE_TIMEOUT_EN
                end else if (timeout_hit) begin
                    // The request is already on the bus; its reply must be
                    // swallowed later so it is not mistaken for the next one.
                    state_d   = Resp;
                    load_resp = 1'b1;
                    err_d     = 1'b1;
                    set_drain = 1'b1;
`endif
                end
            end
            Resp: begin
`ifdef TLUL_HOST_BRIDGE_TIMEOUT_EN
                state_d = drain_q ? Drain : Idle;
`else
                state_d = Idle;
`endif
            end
`ifdef TLUL_HOST_BRIDGE_TIMEOUT_EN
            Drain: begin
                if (tl_i.d_valid) state_d = Idle;
            end
`endif
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= Idle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= we_i;
                addr_q  <= addr_i[31:2];
                wdata_q <= wdata_i;
                be_q    <= be_i;
            end
            if (load_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

`ifdef TLUL_HOST_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
            end else if ((state_q == AReq) || (state_q == DWait)) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (accept) begin
                drain_q <= 1'b0;
            end else if (set_drain) begin
                drain_q <= 1'b1;
            end else if ((state_q == Drain) && tl_i.d_valid) begin
                drain_q <= 1'b0;
            end
        end
    end
`endif

endmodule
